// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - counter-control and host-side signal bundle for uart_rx_ctrl
interface uart_rx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic                 period_flag;
    logic                 bits_flag;
    logic                 period_clear;
    logic                 period_enable;
    logic                 bits_clear;
    logic                 bits_enable;
    logic                 data_read;
    logic [DATA_BITS-1:0] rx_data;
    logic                 data_ready;
    logic                 framing_error;
    logic                 overrun_error;

    modport master (
        input  period_flag, bits_flag, data_read,
        output period_clear, period_enable, bits_clear, bits_enable,
        output rx_data, data_ready, framing_error, overrun_error
    );

    modport slave (
        output period_flag, bits_flag, data_read,
        input  period_clear, period_enable, bits_clear, bits_enable,
        input  rx_data, data_ready, framing_error, overrun_error
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - receive control FSM: start detect, bit sampling, frame check, host flags
module uart_rx_ctrl #(
    parameter int DATA_BITS = 8
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           serial_in,
    uart_rx_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, RECV, CHECK, LOAD} state_t;

    state_t               state;
    logic                 sync_meta;
    logic                 sync;
    logic                 sync_prev;
    logic [DATA_BITS:0]   shift_reg;
    logic                 start_edge;

    assign start_edge = sync_prev & ~sync;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state             <= IDLE;
            sync_meta         <= 1'b1;
            sync              <= 1'b1;
            sync_prev         <= 1'b1;
            shift_reg         <= '1;
            bus.rx_data       <= '0;
            bus.data_ready    <= 1'b0;
            bus.framing_error <= 1'b0;
            bus.overrun_error <= 1'b0;
        end else begin
            sync_meta <= serial_in;
            sync      <= sync_meta;
            sync_prev <= sync;

            // LOAD owns the host flags in its cycle; elsewhere an ack clears them
            if (bus.data_read && bus.data_ready && state != LOAD) begin
                bus.data_ready    <= 1'b0;
                bus.overrun_error <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state             <= CLEAR;
                        bus.framing_error <= 1'b0;
                    end
                end
                CLEAR: state <= RECV;
                RECV: begin
                    if (bus.bits_flag)
                        state <= CHECK;
                    else if (bus.period_flag)
                        shift_reg <= {sync, shift_reg[DATA_BITS:1]};
                end
                CHECK: begin
                    if (shift_reg[DATA_BITS]) begin
                        state <= LOAD;
                    end else begin
                        bus.framing_error <= 1'b1;
                        state             <= IDLE;
                    end
                end
                LOAD: begin
                    bus.rx_data    <= shift_reg[DATA_BITS-1:0];
                    bus.data_ready <= 1'b1;
                    if (bus.data_read)
                        bus.overrun_error <= 1'b0;
                    else if (bus.data_ready)
                        bus.overrun_error <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // counter controls are decoded so the counters see them in the same cycle
    always_comb begin
        bus.period_clear  = (state == CLEAR);
        bus.bits_clear    = (state == CLEAR);
        bus.period_enable = (state == RECV);
        bus.bits_enable   = (state == RECV) && bus.period_flag && !bus.bits_flag;
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed frame-level bench for uart_rx_ctrl with bit-period/bit counter models
module tb_uart_rx_ctrl;
    localparam int DB = 8;
    localparam int R  = 10;

    logic clk;
    logic n_rst;
    logic serial_in;

    uart_rx_ctrl_if #(.DATA_BITS(DB)) bus ();

    uart_rx_ctrl #(.DATA_BITS(DB)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .serial_in (serial_in),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flex counter models: clear to 0, count 1..rollover, flag while at rollover
    int pcnt = 0;
    int bcnt = 0;
    always @(posedge clk) begin
        if (bus.period_clear)       pcnt <= 0;
        else if (bus.period_enable) pcnt <= (pcnt == R) ? 1 : pcnt + 1;
        if (bus.bits_clear)         bcnt <= 0;
        else if (bus.bits_enable)   bcnt <= (bcnt == DB + 1) ? 1 : bcnt + 1;
    end
    assign bus.period_flag = (pcnt == R);
    assign bus.bits_flag   = (bcnt == DB + 1);

    int total = 0;
    int bad   = 0;

    logic [DB-1:0] exp_rx;
    logic          exp_ready;
    logic          exp_fe;
    logic          exp_ov;
    int            ph;      // 0: no counter activity, 1: clearing counters, 2: receiving
    logic          chk_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rx_data", 32'(bus.rx_data), 32'(exp_rx));
            check("data_ready", 32'(bus.data_ready), 32'(exp_ready));
            check("framing_error", 32'(bus.framing_error), 32'(exp_fe));
            check("overrun_error", 32'(bus.overrun_error), 32'(exp_ov));
            case (ph)
                1: begin
                    check("period_clear", 32'(bus.period_clear), 1);
                    check("bits_clear", 32'(bus.bits_clear), 1);
                    check("period_enable", 32'(bus.period_enable), 0);
                    check("bits_enable", 32'(bus.bits_enable), 0);
                end
                2: begin
                    check("period_clear", 32'(bus.period_clear), 0);
                    check("bits_clear", 32'(bus.bits_clear), 0);
                    check("period_enable", 32'(bus.period_enable), 1);
                    check("bits_enable", 32'(bus.bits_enable),
                          32'(bus.period_flag && !bus.bits_flag));
                end
                default: begin
                    check("period_clear", 32'(bus.period_clear), 0);
                    check("bits_clear", 32'(bus.bits_clear), 0);
                    check("period_enable", 32'(bus.period_enable), 0);
                    check("bits_enable", 32'(bus.bits_enable), 0);
                end
            endcase
        end
    end

    // tracks the expected control phase from the start-edge latency
    task automatic model_start();
        repeat (3) @(posedge clk);
        ph     = 1;
        exp_fe = 1'b0;
        @(posedge clk);
        ph = 2;
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input logic stop, input logic rd_load);
        logic [DB+1:0] bits;
        bits = {stop, b, 1'b0};
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < DB + 2; i++) begin
                    serial_in = bits[i];
                    repeat (R) @(negedge clk);
                end
                serial_in = 1'b1;
            end
            begin
                bit found;
                found = 1'b0;
                model_start();
                for (int n = 0; n < 200 && !found; n++) begin
                    @(negedge clk);
                    if (bus.bits_flag) found = 1'b1;
                end
                if (!found) begin
                    check("bits_flag_timeout", 0, 1);
                    ph = 0;
                end else begin
                    @(posedge clk);
                    ph = 0;
                    if (!stop) begin
                        @(posedge clk);
                        exp_fe = 1'b1;
                    end else begin
                        @(posedge clk);
                        if (rd_load) begin
                            @(negedge clk);
                            bus.data_read = 1'b1;
                        end
                        @(posedge clk);
                        exp_ov    = rd_load ? 1'b0 : (exp_ready ? 1'b1 : exp_ov);
                        exp_ready = 1'b1;
                        exp_rx    = b;
                        if (rd_load) begin
                            @(negedge clk);
                            bus.data_read = 1'b0;
                        end
                    end
                end
            end
        join
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_read();
        @(negedge clk);
        bus.data_read = 1'b1;
        @(posedge clk);
        if (exp_ready) begin
            exp_ready = 1'b0;
            exp_ov    = 1'b0;
        end
        @(negedge clk);
        bus.data_read = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_mid_frame(input logic [DB-1:0] b);
        logic [DB+1:0] bits;
        bits = {1'b1, b, 1'b0};
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    serial_in = bits[i];
                    repeat (R) @(negedge clk);
                end
            end
            model_start();
        join
        n_rst     = 1'b1;
        serial_in = 1'b1;
        @(posedge clk);
        exp_rx    = '0;
        exp_ready = 1'b0;
        exp_fe    = 1'b0;
        exp_ov    = 1'b0;
        ph        = 0;
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        n_rst         = 1'b1;
        serial_in     = 1'b1;
        bus.data_read = 1'b0;
        chk_en        = 1'b0;
        exp_rx        = '0;
        exp_ready     = 1'b0;
        exp_fe        = 1'b0;
        exp_ov        = 1'b0;
        ph            = 0;
        repeat (2) @(negedge clk);
        n_rst  = 1'b0;
        chk_en = 1'b1;

        check("reset_rx_data", 32'(bus.rx_data), 0);
        check("reset_data_ready", 32'(bus.data_ready), 0);
        repeat (50) @(negedge clk);

        send_frame(8'hA5, 1'b1, 1'b0);
        check("lit_a5_rx", 32'(bus.rx_data), 32'h A5);
        check("lit_a5_ready", 32'(bus.data_ready), 1);
        pulse_read();
        check("lit_a5_read_ready", 32'(bus.data_ready), 0);

        send_frame(8'h3C, 1'b0, 1'b0);
        check("lit_fe_set", 32'(bus.framing_error), 1);
        check("lit_fe_ready", 32'(bus.data_ready), 0);
        check("lit_fe_rx_kept", 32'(bus.rx_data), 32'h A5);
        pulse_read();
        check("lit_fe_sticky", 32'(bus.framing_error), 1);
        send_frame(8'h11, 1'b1, 1'b0);
        check("lit_11_rx", 32'(bus.rx_data), 32'h 11);
        check("lit_11_fe_cleared", 32'(bus.framing_error), 0);
        pulse_read();

        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b0);
        check("lit_ov_rx", 32'(bus.rx_data), 32'h AA);
        check("lit_ov_ready", 32'(bus.data_ready), 1);
        check("lit_ov_set", 32'(bus.overrun_error), 1);
        pulse_read();
        check("lit_ov_clr_ready", 32'(bus.data_ready), 0);
        check("lit_ov_clr", 32'(bus.overrun_error), 0);

        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'h77, 1'b1, 1'b1);
        check("lit_col_ready", 32'(bus.data_ready), 1);
        check("lit_col_rx", 32'(bus.rx_data), 32'h 77);
        check("lit_col_ov", 32'(bus.overrun_error), 0);

        reset_mid_frame(8'h96);
        check("lit_rst_rx", 32'(bus.rx_data), 0);
        check("lit_rst_ready", 32'(bus.data_ready), 0);
        check("lit_rst_period_enable", 32'(bus.period_enable), 0);
        send_frame(8'hC3, 1'b1, 1'b0);
        check("lit_c3_rx", 32'(bus.rx_data), 32'h C3);
        check("lit_c3_ov", 32'(bus.overrun_error), 0);
        pulse_read();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
